// File: rtl/sdram_sched.sv
// sdram_sched: arbitrates auto-refresh, write-drain and read-fill bursts onto one SDRAM
// command engine and generates wrapping frame addresses for both FIFO ports.
module sdram_sched #(
    parameter int              ADDR_W     = 24,
    parameter int              LEN_W      = 10,
    parameter int              REF_PERIOD = 781,
    parameter int              WR_BURST   = 512,
    parameter int              RD_BURST   = 512,
    parameter logic [ADDR_W-1:0] WR_BASE  = '0,
    parameter logic [ADDR_W-1:0] WR_END   = 24'h0BB800,
    parameter logic [ADDR_W-1:0] RD_BASE  = '0,
    parameter logic [ADDR_W-1:0] RD_END   = 24'h0BB800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic [LEN_W-1:0]  wr_level,
    input  logic              wr_flush,
    input  logic              wr_frame_rst,
    input  logic              rd_en,
    input  logic [LEN_W-1:0]  rd_space,
    input  logic              rd_frame_rst,
    output logic              cmd_valid,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ack,
    input  logic              cmd_done,
    output logic              busy,
    output logic              ref_miss
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic [1:0] T_WR = 2'b00, T_RD = 2'b01, T_REF = 2'b10;
    localparam int CW = $clog2(REF_PERIOD);
    state_t state_q, state_d;
    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic ref_pend_q, ref_pend_d, ref_miss_q, ref_miss_d, last_rd_q, last_rd_d;
    logic wr_frp_q, wr_frp_d, rd_frp_q, rd_frp_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic cmd_valid_q, cmd_valid_d;
    logic [1:0] cmd_type_q, cmd_type_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d, wr_adv, rd_adv;
    logic [LEN_W-1:0] cmd_len_q, cmd_len_d, wr_len;
    logic [ADDR_W:0] nxt;
    logic wr_full, wr_req, rd_req, can_grant, grant_ref, grant_wr, grant_rd, grant;
    logic ack, done, in_wr, in_rd, ref_tc;

    assign wr_full   = wr_level >= LEN_W'(WR_BURST);
    assign wr_req    = wr_full || (wr_flush && wr_level != '0);
    assign rd_req    = rd_en && rd_space >= LEN_W'(RD_BURST);
    assign wr_len    = wr_full ? LEN_W'(WR_BURST) : wr_level;
    assign can_grant = state_q == IDLE && init_done;
    assign grant_ref = can_grant && ref_pend_q;
    assign grant_wr  = can_grant && !ref_pend_q && wr_req && (!rd_req || last_rd_q);
    assign grant_rd  = can_grant && !ref_pend_q && rd_req && (!wr_req || !last_rd_q);
    assign grant     = grant_ref || grant_wr || grant_rd;
    assign ack       = state_q == ISSUE && cmd_ack;
    assign done      = (state_q == WAIT || ack) && cmd_done;
    assign in_wr     = state_q != IDLE && cmd_type_q == T_WR;
    assign in_rd     = state_q != IDLE && cmd_type_q == T_RD;
    assign ref_tc    = init_done && ref_cnt_q == CW'(REF_PERIOD - 1);
    // Wrap early so a full nominal burst always fits before the region end.
    assign nxt       = {1'b0, cmd_addr_q} + {{(ADDR_W + 1 - LEN_W){1'b0}}, cmd_len_q};
    assign wr_adv    = nxt + (ADDR_W + 1)'(WR_BURST) > {1'b0, WR_END} ? WR_BASE : nxt[ADDR_W-1:0];
    assign rd_adv    = nxt + (ADDR_W + 1)'(RD_BURST) > {1'b0, RD_END} ? RD_BASE : nxt[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ref_cnt_q   <= '0;
            ref_pend_q  <= 1'b0;
            ref_miss_q  <= 1'b0;
            last_rd_q   <= 1'b1;
            wr_frp_q    <= 1'b0;
            rd_frp_q    <= 1'b0;
            wr_addr_q   <= WR_BASE;
            rd_addr_q   <= RD_BASE;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= T_WR;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_pend_q  <= ref_pend_d;
            ref_miss_q  <= ref_miss_d;
            last_rd_q   <= last_rd_d;
            wr_frp_q    <= wr_frp_d;
            rd_frp_q    <= rd_frp_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
        end
    end

    always_comb begin
        state_d = grant ? ISSUE : done ? IDLE : ack ? WAIT : state_q;
    end

    always_comb begin
        cmd_valid_d = grant ? 1'b1 : ack ? 1'b0 : cmd_valid_q;
        cmd_type_d  = grant_ref ? T_REF : grant_rd ? T_RD : grant_wr ? T_WR : cmd_type_q;
        cmd_addr_d  = grant_ref ? '0 : grant_rd ? (rd_frame_rst ? RD_BASE : rd_addr_q)
                    : grant_wr ? (wr_frame_rst ? WR_BASE : wr_addr_q) : cmd_addr_q;
        cmd_len_d   = grant_ref ? '0 : grant_rd ? LEN_W'(RD_BURST) : grant_wr ? wr_len : cmd_len_q;
    end

    // Frame resets arriving mid-burst are held and replace the advance at completion.
    always_comb begin
        ref_cnt_d  = (!init_done || ref_tc) ? '0 : ref_cnt_q + 1'b1;
        ref_pend_d = ref_tc || (ref_pend_q && !(ack && cmd_type_q == T_REF));
        ref_miss_d = ref_miss_q || (ref_tc && ref_pend_q);
        last_rd_d  = (done && cmd_type_q != T_REF) ? cmd_type_q == T_RD : last_rd_q;
        wr_frp_d   = in_wr && !done && (wr_frp_q || wr_frame_rst);
        rd_frp_d   = in_rd && !done && (rd_frp_q || rd_frame_rst);
        wr_addr_d  = ((wr_frame_rst || wr_frp_q) && (!in_wr || done)) ? WR_BASE
                   : (done && in_wr) ? wr_adv : wr_addr_q;
        rd_addr_d  = ((rd_frame_rst || rd_frp_q) && (!in_rd || done)) ? RD_BASE
                   : (done && in_rd) ? rd_adv : rd_addr_q;
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign busy      = state_q != IDLE;
    assign ref_miss  = ref_miss_q;
endmodule

// File: tb/tb_sdram_sched.sv
// tb_sdram_sched: drives the scheduler as FIFO ports and as the SDRAM core, checking every
// cycle against a transaction-level model of the arbitration, refresh and address rules.
module tb_sdram_sched;
    localparam int AW = 24, LW = 10, RP = 781, WB = 512, RB = 512, WEND = 1536, REND = 2048;
    logic clk = 0, rst = 1, init_done = 0, wr_flush = 0, wr_frame_rst = 0;
    logic rd_en = 0, rd_frame_rst = 0, cmd_ack = 0, cmd_done = 0;
    logic [LW-1:0] wr_level = '0, rd_space = '0;
    logic cmd_valid, busy, ref_miss;
    logic [1:0] cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    int vectors = 0, miscompares = 0;
    int m_cnt, m_out, m_type, m_addr, m_len, m_wa, m_ra;
    bit m_pend, m_miss, m_last_rd, m_wfr, m_rfr;
    bit stall = 0, hold = 0, prev_valid = 0;
    int g_type[$], g_addr[$], g_len[$];

    sdram_sched #(.WR_END(24'(WEND)), .RD_END(24'(REND))) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .wr_level(wr_level), .wr_flush(wr_flush),
        .wr_frame_rst(wr_frame_rst), .rd_en(rd_en), .rd_space(rd_space),
        .rd_frame_rst(rd_frame_rst), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ack(cmd_ack), .cmd_done(cmd_done),
        .busy(busy), .ref_miss(ref_miss)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            if (miscompares <= 25) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int advance(int a, int l, int burst, int fin);
        return (a + l + burst > fin) ? 0 : a + l;
    endfunction

    // One clock edge of the reference: grant, completion, frame resets and refresh timer.
    task automatic model_edge();
        bit wreq, rreq, tc;
        bit pend_pre = m_pend;
        if (rst) begin
            m_cnt = 0; m_out = 0; m_pend = 0; m_miss = 0; m_last_rd = 1;
            m_wa = 0; m_ra = 0; m_wfr = 0; m_rfr = 0;
            return;
        end
        wreq = wr_level >= WB || (wr_flush && wr_level != 0);
        rreq = rd_en && rd_space >= RB;
        tc = init_done && m_cnt == RP - 1;
        if (wr_frame_rst) begin if (m_out != 0 && m_type == 0) m_wfr = 1; else m_wa = 0; end
        if (rd_frame_rst) begin if (m_out != 0 && m_type == 1) m_rfr = 1; else m_ra = 0; end
        if (m_out == 0) begin
            if (init_done && pend_pre) begin
                m_type = 2; m_addr = 0; m_len = 0; m_out = 1;
            end else if (init_done && wreq && (!rreq || m_last_rd)) begin
                m_type = 0; m_addr = m_wa; m_len = wr_level >= WB ? WB : int'(wr_level); m_out = 1;
            end else if (init_done && rreq) begin
                m_type = 1; m_addr = m_ra; m_len = RB; m_out = 1;
            end
        end else begin
            if (m_out == 1 && cmd_ack) begin
                if (m_type == 2) m_pend = 0;
                m_out = 2;
            end
            if (m_out == 2 && cmd_done) begin
                if (m_type == 0) begin
                    m_wa = m_wfr ? 0 : advance(m_addr, m_len, WB, WEND); m_wfr = 0; m_last_rd = 0;
                end else if (m_type == 1) begin
                    m_ra = m_rfr ? 0 : advance(m_addr, m_len, RB, REND); m_rfr = 0; m_last_rd = 1;
                end
                m_out = 0;
            end
        end
        if (tc && pend_pre) m_miss = 1;
        if (tc) m_pend = 1;
        m_cnt = (!init_done || tc) ? 0 : m_cnt + 1;
    endtask

    task automatic cycle(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check("valid", cmd_valid, int'(m_out == 1));
            check("busy", busy, int'(m_out != 0));
            check("ref_miss", ref_miss, int'(m_miss));
            if (m_out == 1) begin
                check("type", cmd_type, m_type);
                check("addr", cmd_addr, m_addr);
                check("len", cmd_len, m_len);
            end
            if (cmd_valid && !prev_valid) begin
                g_type.push_back(cmd_type); g_addr.push_back(cmd_addr); g_len.push_back(cmd_len);
            end
            prev_valid = cmd_valid;
            cmd_ack = 0;
            cmd_done = 0;
            if (m_out == 1 && !stall && $urandom_range(2) != 0) begin
                cmd_ack = 1;
                cmd_done = !hold && $urandom_range(5) == 0;
            end else if (m_out == 2 && !hold && $urandom_range(3) == 0) cmd_done = 1;
        end
    endtask

    task automatic clear_grants();
        g_type.delete(); g_addr.delete(); g_len.delete();
    endtask

    task automatic drain();
        wr_level = 0; wr_flush = 0; rd_en = 0;
        for (int i = 0; i < 300 && m_out != 0; i++) cycle();
        check("drain_timeout", m_out, 0);
        cycle();
    endtask

    task automatic wait_grants(int n);
        for (int i = 0; i < 3000 && g_type.size() < n; i++) cycle();
        check("grant_timeout", int'(g_type.size() >= n), 1);
    endtask

    task automatic wait_out(int st);
        for (int i = 0; i < 3000 && m_out != st; i++) cycle();
        check("state_timeout", m_out, st);
    endtask

    task automatic pulse_frame(bit w, bit r);
        wr_frame_rst = w; rd_frame_rst = r;
        cycle();
        wr_frame_rst = 0; rd_frame_rst = 0;
    endtask

    initial begin
        cycle(3);
        check("rst_type", cmd_type, 0);
        check("rst_addr", cmd_addr, 0);
        check("rst_len", cmd_len, 0);
        rst = 0;
        wr_level = 600;
        cycle(2000);
        check("pre_init_idle", busy, 0);
        wr_level = 0;
        init_done = 1;
        clear_grants();
        cycle(2 * RP + 20);
        check("ref_count", g_type.size(), 2);
        stall = 1;
        cycle(1600);
        check("ref_miss_stall", ref_miss, 1);
        stall = 0;
        cycle(20);
        rst = 1; cycle(2); rst = 0;

        clear_grants();
        wr_level = 512; rd_en = 1; rd_space = 512;
        wait_grants(4);
        for (int i = 0; i < 4 && i < g_type.size(); i++) begin
            check("alt_type", g_type[i], i % 2);
            check("alt_addr", g_addr[i], (i / 2) * 512);
            check("alt_len", g_len[i], 512);
        end

        drain();
        pulse_frame(1, 0);
        clear_grants();
        wr_level = 37; wr_flush = 1;
        wait_grants(2);
        if (g_type.size() >= 2) begin
            check("flush_len", g_len[0], 37);
            check("flush_addr0", g_addr[0], 0);
            check("flush_addr1", g_addr[1], 37);
        end

        drain();
        pulse_frame(1, 0);
        clear_grants();
        wr_level = 512;
        wait_grants(4);
        for (int i = 0; i < 4 && i < g_type.size(); i++) check("wrap_addr", g_addr[i], (i % 3) * 512);

        drain();
        pulse_frame(0, 1);
        clear_grants();
        rd_en = 1; rd_space = 512;
        wait_grants(1);
        wait_out(2);
        pulse_frame(0, 1);
        wait_grants(2);
        if (g_type.size() >= 2) check("rd_frame_addr", g_addr[1], 0);

        drain();
        rd_en = 1;
        hold = 1;
        wait_out(2);
        rd_en = 0; wr_level = 512;
        for (int i = 0; i < 2 * RP && !m_pend; i++) cycle();
        clear_grants();
        hold = 0;
        wait_grants(2);
        if (g_type.size() >= 2) begin
            check("prio_ref", g_type[0], 2);
            check("prio_wr", g_type[1], 0);
        end

        drain();
        wr_level = 512;
        hold = 1;
        wait_out(2);
        rst = 1;
        cycle();
        check("rst_wait_valid", cmd_valid, 0);
        check("rst_wait_busy", busy, 0);
        rst = 0;
        hold = 0;

        repeat (600) begin
            wr_level = LW'($urandom_range(0, 700));
            wr_flush = $urandom_range(1) == 1;
            rd_en = $urandom_range(2) != 0;
            rd_space = LW'($urandom_range(300, 700));
            pulse_frame($urandom_range(7) == 0, $urandom_range(7) == 0);
            cycle($urandom_range(1, 40));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
